// File: rtl/simd_lane_alu.sv
// simd_lane_alu: registered lane-wise 8-bit vector ALU with fixed one-cycle latency.
// Optional macro SIMD_LANE_ALU_SAT_FLAG_EN adds the registered per-lane sat_mask output.
module simd_lane_alu #(
    parameter int LANES  = 16,
    parameter int LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              aluVectorOp,
    input  logic [LANES*LANE_W-1:0] srcA_vector,
    input  logic [LANES*LANE_W-1:0] srcB_vector,
    output logic [LANES*LANE_W-1:0] result_vector
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
    ,
    output logic [LANES-1:0]        sat_mask
`endif
);

    localparam int VEC_W = LANES * LANE_W;

    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_VADD   = 5'b00001;
    localparam logic [4:0] OP_VSUB   = 5'b00010;
    localparam logic [4:0] OP_VMUL   = 5'b00011;
    localparam logic [4:0] OP_VAND   = 5'b00100;
    localparam logic [4:0] OP_VOR    = 5'b00101;
    localparam logic [4:0] OP_VXOR   = 5'b00110;
    localparam logic [4:0] OP_VSHL   = 5'b00111;
    localparam logic [4:0] OP_VSHR   = 5'b01000;
    localparam logic [4:0] OP_VADDS  = 5'b01001;
    localparam logic [4:0] OP_VSUBS  = 5'b01010;
    localparam logic [4:0] OP_VMIN   = 5'b01011;
    localparam logic [4:0] OP_VMAX   = 5'b01100;
    localparam logic [4:0] OP_VPASSA = 5'b01101;
    localparam logic [4:0] OP_VBCAST = 5'b01110;
    localparam logic [4:0] OP_VROTL  = 5'b01111;

    wire  [VEC_W-1:0] next_result_s;
    logic [VEC_W-1:0] result_r;
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
    wire  [LANES-1:0] next_sat_s;
    logic [LANES-1:0] sat_r;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] a_s;
        logic [LANE_W-1:0] b_s;
        logic [2:0]        sh_s;
        logic [LANE_W:0]   sum_s;
        logic [LANE_W:0]   diff_s;
        logic [LANE_W-1:0] mul_s;
        logic [LANE_W-1:0] res_s;

        assign a_s    = srcA_vector[i*LANE_W +: LANE_W];
        assign b_s    = srcB_vector[i*LANE_W +: LANE_W];
        assign sh_s   = b_s[2:0];
        // Ninth bit of sum/diff is the carry/borrow that drives saturation.
        assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
        assign diff_s = {1'b0, a_s} - {1'b0, b_s};
        assign mul_s  = a_s * b_s;

        // Per-lane operation decode; reserved opcodes fall to zero.
        always_comb begin
            res_s = {LANE_W{1'b0}};
            case (aluVectorOp)
                OP_NOP:    res_s = {LANE_W{1'b0}};
                OP_VADD:   res_s = sum_s[LANE_W-1:0];
                OP_VSUB:   res_s = diff_s[LANE_W-1:0];
                OP_VMUL:   res_s = mul_s;
                OP_VAND:   res_s = a_s & b_s;
                OP_VOR:    res_s = a_s | b_s;
                OP_VXOR:   res_s = a_s ^ b_s;
                OP_VSHL:   res_s = a_s << sh_s;
                OP_VSHR:   res_s = a_s >> sh_s;
                OP_VADDS:  res_s = sum_s[LANE_W] ? {LANE_W{1'b1}} : sum_s[LANE_W-1:0];
                OP_VSUBS:  res_s = diff_s[LANE_W] ? {LANE_W{1'b0}} : diff_s[LANE_W-1:0];
                OP_VMIN:   res_s = (a_s < b_s) ? a_s : b_s;
                OP_VMAX:   res_s = (a_s > b_s) ? a_s : b_s;
                OP_VPASSA: res_s = a_s;
                OP_VBCAST: res_s = srcB_vector[LANE_W-1:0];
                OP_VROTL:  res_s = (a_s << sh_s) | (a_s >> (LANE_W - int'(sh_s)));
                default:   res_s = {LANE_W{1'b0}};
            endcase
        end

        assign next_result_s[i*LANE_W +: LANE_W] = res_s;
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
        assign next_sat_s[i] = ((aluVectorOp == OP_VADDS) && sum_s[LANE_W]) ||
                               ((aluVectorOp == OP_VSUBS) && diff_s[LANE_W]);
`endif
    end

    // Single output register stage; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {VEC_W{1'b0}};
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
            sat_r    <= {LANES{1'b0}};
`endif
        end else begin
            result_r <= next_result_s;
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
            sat_r    <= next_sat_s;
`endif
        end
    end

    assign result_vector = result_r;
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
    assign sat_mask      = sat_r;
`endif

endmodule

// File: tb/tb_simd_lane_alu.sv
// Self-checking bench for simd_lane_alu: directed steps plus random ops against a lane model.
module tb_simd_lane_alu;

    logic         clk;
    logic         reset;
    logic [4:0]   aluVectorOp;
    logic [127:0] srcA_vector;
    logic [127:0] srcB_vector;
    logic [127:0] result_vector;
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
    logic [15:0]  sat_mask;
`endif

    int tests = 0;
    int fails = 0;

    simd_lane_alu dut (
        .clk           (clk),
        .reset         (reset),
        .aluVectorOp   (aluVectorOp),
        .srcA_vector   (srcA_vector),
        .srcB_vector   (srcB_vector),
        .result_vector (result_vector)
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
        ,
        .sat_mask      (sat_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each lane evaluated with plain integer arithmetic.
    function automatic logic [127:0] model(input logic [4:0] op, input logic [127:0] a, input logic [127:0] b);
        logic [127:0] out;
        int x, y, s, r;
        out = 128'h0;
        for (int i = 0; i < 16; i++) begin
            x = int'(a[i*8 +: 8]);
            y = int'(b[i*8 +: 8]);
            s = y % 8;
            case (op)
                5'd1:    r = (x + y) % 256;
                5'd2:    r = (x - y + 256) % 256;
                5'd3:    r = (x * y) % 256;
                5'd4:    r = x & y;
                5'd5:    r = x | y;
                5'd6:    r = x ^ y;
                5'd7:    r = (x * (1 << s)) % 256;
                5'd8:    r = x / (1 << s);
                5'd9:    r = (x + y > 255) ? 255 : x + y;
                5'd10:   r = (x < y) ? 0 : x - y;
                5'd11:   r = (x < y) ? x : y;
                5'd12:   r = (x > y) ? x : y;
                5'd13:   r = x;
                5'd14:   r = int'(b[7:0]);
                5'd15:   r = ((x * (1 << s)) + (x / (1 << (8 - s)))) % 256;
                default: r = 0;
            endcase
            out[i*8 +: 8] = r[7:0];
        end
        return out;
    endfunction

    function automatic logic [15:0] model_sat(input logic [4:0] op, input logic [127:0] a, input logic [127:0] b);
        logic [15:0] m;
        int x, y;
        m = 16'h0;
        for (int i = 0; i < 16; i++) begin
            x = int'(a[i*8 +: 8]);
            y = int'(b[i*8 +: 8]);
            m[i] = ((op == 5'd9) && (x + y > 255)) || ((op == 5'd10) && (x < y));
        end
        return m;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of inputs, then compare the registered result with the model.
    task automatic step(input string tag, input logic rst, input logic [4:0] op,
                        input logic [127:0] a, input logic [127:0] b);
        logic [127:0] exp;
        reset = rst; aluVectorOp = op; srcA_vector = a; srcB_vector = b;
        @(posedge clk);
        #1;
        exp = rst ? 128'h0 : model(op, a, b);
        tests++;
        assert (result_vector === exp) else begin
            fails++;
            $error("FAIL %s: result got %h expected %h", tag, result_vector, exp);
        end
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
        tests++;
        assert (sat_mask === (rst ? 16'h0 : model_sat(op, a, b))) else begin
            fails++;
            $error("FAIL %s_sat: sat_mask got %h expected %h", tag, sat_mask, model_sat(op, a, b));
        end
`endif
    endtask

    task automatic check_const(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [127:0] b_bc;
        logic [4:0]   rop;

        reset = 1'b1; aluVectorOp = 5'd1;
        srcA_vector = {16{8'hA5}}; srcB_vector = {16{8'h3C}};

        step("reset0", 1'b1, 5'd9, {16{8'hFF}}, {16{8'h01}});
        step("reset1", 1'b1, 5'd9, {16{8'hFF}}, {16{8'h01}});
        step("first_vadd", 1'b0, 5'd1, {16{8'h01}}, {16{8'h02}});
        check_const("first_vadd_c", result_vector, {16{8'h03}});

        step("vadd_wrap", 1'b0, 5'd1, {16{8'hFF}}, {16{8'h01}});
        check_const("vadd_wrap_c", result_vector, 128'h0);
        step("vadds_clip", 1'b0, 5'd9, {16{8'hFF}}, {16{8'h01}});
        check_const("vadds_clip_c", result_vector, {16{8'hFF}});
`ifdef SIMD_LANE_ALU_SAT_FLAG_EN
        check_const("vadds_sat_c", {112'h0, sat_mask}, {112'h0, 16'hFFFF});
`endif
        step("vsubs_clip", 1'b0, 5'd10, {16{8'h00}}, {16{8'h05}});
        check_const("vsubs_clip_c", result_vector, 128'h0);
        step("vsub_wrap", 1'b0, 5'd2, {16{8'h00}}, {16{8'h01}});
        check_const("vsub_wrap_c", result_vector, {16{8'hFF}});

        step("lane_iso", 1'b0, 5'd1, {120'h0, 8'hFF}, {120'h0, 8'h01});
        check_const("lane_iso_l1", {120'h0, result_vector[15:8]}, 128'h0);
        step("vmul_ff", 1'b0, 5'd3, {16{8'hFF}}, {16{8'hFF}});
        check_const("vmul_ff_c", result_vector, {16{8'h01}});

        step("vshl", 1'b0, 5'd7, {16{8'h81}}, {16{8'h09}});
        check_const("vshl_c", result_vector, {16{8'h02}});
        step("vshr", 1'b0, 5'd8, {16{8'h81}}, {16{8'h09}});
        check_const("vshr_c", result_vector, {16{8'h40}});
        step("vrotl", 1'b0, 5'd15, {16{8'h81}}, {16{8'h09}});
        check_const("vrotl_c", result_vector, {16{8'h03}});
        step("vrotl_s0", 1'b0, 5'd15, {16{8'h81}}, {16{8'hF8}});
        check_const("vrotl_s0_c", result_vector, {16{8'h81}});

        b_bc = rnd128();
        b_bc[7:0] = 8'h5A;
        step("vbcast", 1'b0, 5'd14, rnd128(), b_bc);
        check_const("vbcast_c", result_vector, {16{8'h5A}});
        step("vmin", 1'b0, 5'd11, {16{8'h10}}, {16{8'h20}});
        check_const("vmin_c", result_vector, {16{8'h10}});
        step("vmax", 1'b0, 5'd12, {16{8'h10}}, {16{8'h20}});
        check_const("vmax_c", result_vector, {16{8'h20}});

        for (int op = 0; op < 16; op++) begin
            step($sformatf("b2b_op%0d", op), 1'b0, 5'(op), rnd128(), rnd128());
        end
        step("reserved_10101", 1'b0, 5'b10101, rnd128(), rnd128());
        check_const("reserved_c", result_vector, 128'h0);

        step("midreset_op", 1'b0, 5'd6, rnd128(), rnd128());
        step("midreset", 1'b1, 5'd1, rnd128(), rnd128());
        check_const("midreset_c", result_vector, 128'h0);
        step("after_reset", 1'b0, 5'd13, rnd128(), rnd128());

        for (int k = 0; k < 300; k++) begin
            rop = 5'($urandom_range(0, 31));
            step("random", 1'b0, rop, rnd128(), rnd128());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simd_lane_alu.md
Name: simd_lane_alu

Overview:
- Registered vector ALU for the execute stage of the vector datapath.
- Performs lane-wise 8-bit integer operations on two 128-bit operands.
- Operands are the post-forwarding vector sources; result feeds the Execute-Memory pipeline register.
- Single clock domain, fixed one-cycle latency, no handshake.

Parameters:
- LANES, 16, number of independent lanes.
- LANE_W, 8, bits per lane; vector width is LANES*LANE_W (128 by default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- aluVectorOp  input  5  operation select.
- srcA_vector  input  LANES*LANE_W  operand A; lane i = bits [i*LANE_W +: LANE_W], lane 0 = bits [7:0].
- srcB_vector  input  LANES*LANE_W  operand B, same lane layout.
- result_vector  output  LANES*LANE_W  registered lane-wise result.

Behaviour:
- One clock; reset is synchronous and active-high.
- On a rising clk edge with reset=1: result_vector <= 0 (all lanes 0x00).
- On a rising clk edge with reset=0: result_vector <= f(aluVectorOp, srcA_vector, srcB_vector), sampled at that edge.
- Latency is exactly 1 cycle. Inputs are sampled every cycle; there is no stall or enable.
- All lanes are independent. No carry, borrow or shift crosses a lane boundary.
- Unsigned arithmetic. Per lane, a = A lane, b = B lane, s = b[2:0]:
  - 00000 NOP: 0.
  - 00001 VADD: (a+b) mod 256.
  - 00010 VSUB: (a-b) mod 256.
  - 00011 VMUL: low 8 bits of a*b.
  - 00100 VAND: a&b.
  - 00101 VOR: a|b.
  - 00110 VXOR: a^b.
  - 00111 VSHL: a<<s, zero fill.
  - 01000 VSHR: a>>s, logical.
  - 01001 VADDS: min(a+b, 255).
  - 01010 VSUBS: max(a-b, 0).
  - 01011 VMIN: unsigned min(a,b).
  - 01100 VMAX: unsigned max(a,b).
  - 01101 VPASSA: a.
  - 01110 VBCAST: B lane 0 copied into every lane.
  - 01111 VROTL: a rotated left by s.
  - 10000-11111: reserved; result 0 with no side effect.
- Shift and rotate amounts use only b[2:0]; b[7:3] is ignored. Shift by 0 returns a unchanged.
- Boundaries:
  - VADD 0xFF+0x01 wraps to 0x00.
  - VSUB 0x00-0x01 gives 0xFF.
  - VADDS and VSUBS clip to 0xFF and 0x00 respectively.
  - VMUL 0xFF*0xFF gives 0x01.
- Reset asserted mid-stream: the output is 0 on the following edge and the pending op is discarded. The first op after deassertion appears one cycle later.
- The core datapath is pure combinational per lane, followed by a single output register. Implement with a generate loop over LANES.

Optional Feature:
- Macro SIMD_LANE_ALU_SAT_FLAG_EN.
- When defined:
  - Adds output port sat_mask [LANES-1:0], registered alongside result_vector.
  - Bit i is set when lane i of a VADDS or VSUBS op clipped, i.e. the true result was >255 or <0.
  - All bits are 0 for every other op and after reset.
- When undefined: the port and its logic are absent, and saturating ops still saturate identically.

Test Plan:
- Reset: hold reset=1 for 2 cycles with nonzero inputs -> result_vector=0 (and sat_mask=0 if enabled). Deassert with op=VADD, all A lanes 0x01, all B lanes 0x02 -> every lane 0x03 exactly one cycle later.
- Wrap vs saturate: A lanes 0xFF, B lanes 0x01. VADD -> all 0x00. VADDS -> all 0xFF (sat_mask=0xFFFF). VSUBS with A=0x00 and B=0x05 -> all 0x00.
- Lane isolation: A=0x00..00FF, B=0x00..0001, VADD -> lane 0=0x00 and lane 1 unchanged at 0x00 (no carry crosses lanes). VMUL 0xFF*0xFF -> 0x01.
- Shifts and rotate: A lanes 0x81, B lanes 0x09 (s=1). VSHL -> 0x02. VSHR -> 0x40. VROTL -> 0x03.
- Broadcast and min/max: B lane 0=0x5A, other lanes random, VBCAST -> all lanes 0x5A. A lane=0x10 and B lane=0x20: VMIN -> 0x10, VMAX -> 0x20.
- Back-to-back and reserved ops: change op every cycle through 00000..01111, then 10101 -> each result matches its op one cycle later, and 10101 yields all zeros.
